// File: rtl/nios_ii_debug_slave_cmd_queue_if.sv
// Command/handshake bundle between the virtual-JTAG front end, the system-clock
// command queue and the OCI consumer.
interface nios_ii_debug_slave_cmd_queue_if #(
  parameter int IR_W  = 2,
  parameter int SR_W  = 38,
  parameter int DEPTH = 4
);
  localparam int NCMD = 2 ** IR_W;
  localparam int LW   = $clog2(DEPTH) + 1;

  logic            vs_uir;
  logic            vs_udr;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            cmd_ready;
  logic            clr_overflow;
  logic            cmd_valid;
  logic [IR_W-1:0] cmd_ir;
  logic [SR_W-1:0] jdo;
  logic [NCMD-1:0] take_action;
  logic [NCMD-1:0] take_no_action;
  logic            overflow;
  logic [LW-1:0]   fifo_level;

  modport slave (
    input  vs_uir, vs_udr, ir_in, sr, cmd_ready, clr_overflow,
    output cmd_valid, cmd_ir, jdo, take_action, take_no_action, overflow, fifo_level
  );

  modport master (
    output vs_uir, vs_udr, ir_in, sr, cmd_ready, clr_overflow,
    input  cmd_valid, cmd_ir, jdo, take_action, take_no_action, overflow, fifo_level
  );
endinterface

// File: rtl/nios_ii_debug_slave_cmd_queue.sv
// System-clock back end of the Nios II JTAG debug slave: synchronises the
// update-IR/DR strobes, queues completed commands and drains them as pulses.
module nios_ii_debug_slave_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int SR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = 34
) (
  input  logic clk,
  input  logic reset_n,
  nios_ii_debug_slave_cmd_queue_if.slave bus
);
  localparam int NCMD = 2 ** IR_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int EW   = IR_W + SR_W;

  // Handshake: a command transfers on every clk edge where cmd_valid and
  // cmd_ready are both high; cmd_valid/cmd_ir do not depend on cmd_ready.

  logic [SYNC_STAGES-1:0] uir_sync, udr_sync;
  logic                   uir_d, udr_d;
  logic                   uir_stb, udr_stb;
  logic [IR_W-1:0]        ir_reg;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [SR_W-1:0] jdo_q;
  logic [NCMD-1:0] act_q, noact_q;
  logic            ovf_q;

  logic            valid, full, pop, push_ok, drop;
  logic [EW-1:0]   head;
  logic [IR_W-1:0] head_ir;
  logic [SR_W-1:0] head_data;
  logic [NCMD-1:0] head_onehot;

  // Rising-edge strobes are registered so ir_reg and the push see one clean pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_d    <= 1'b0;
      udr_d    <= 1'b0;
      uir_stb  <= 1'b0;
      udr_stb  <= 1'b0;
      ir_reg   <= '0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
      uir_d    <= uir_sync[SYNC_STAGES-1];
      udr_d    <= udr_sync[SYNC_STAGES-1];
      uir_stb  <= uir_sync[SYNC_STAGES-1] & ~uir_d;
      udr_stb  <= udr_sync[SYNC_STAGES-1] & ~udr_d;
      if (uir_stb) ir_reg <= bus.ir_in;
    end
  end

  always_comb begin
    head        = mem[rd_ptr];
    head_ir     = head[EW-1:SR_W];
    head_data   = head[SR_W-1:0];
    head_onehot = {{(NCMD-1){1'b0}}, 1'b1} << head_ir;
    valid       = (level != '0);
    full        = (level == LW'(DEPTH));
    pop         = valid & bus.cmd_ready;
    push_ok     = udr_stb & (~full | pop);
    drop        = udr_stb & full & ~pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      jdo_q   <= '0;
      act_q   <= '0;
      noact_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {ir_reg, bus.sr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      act_q   <= '0;
      noact_q <= '0;
      if (pop) begin
        jdo_q <= head_data;
        if (head_data[ACT_BIT]) act_q   <= head_onehot;
        else                    noact_q <= head_onehot;
      end

      // A drop in the same cycle as a clear must stay visible.
      if (drop)                  ovf_q <= 1'b1;
      else if (bus.clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign bus.cmd_valid      = valid;
  assign bus.cmd_ir         = head_ir;
  assign bus.jdo            = jdo_q;
  assign bus.take_action    = act_q;
  assign bus.take_no_action = noact_q;
  assign bus.overflow       = ovf_q;
  assign bus.fifo_level     = level;
endmodule
